iob_eth_init_seq: RTL
=====================

// Module: iob_eth_init_seq
// PURPOSE
// Boot-time configuration sequencer for the ethmac core. Drives the core's IOb register slave port.
// On start it programs MII clock divider, MAC address, TX BD count and interrupt mask, then polls PHY BMSR via MIIM until link is up.
// It then enables TX/RX in MODER. The top level gives it the ethmac slave port while busy=1; the CPU owns the port otherwise.
// PARAMETERS
// ADDR_W      12             register address width (byte address)
// DATA_W      32             data width; fixed at 32
// MAC_ADDR    48'h0200_0000_0001  station MAC; [31:0]->MAC_ADDR0, [47:32]->MAC_ADDR1
// PHY_ADDR    5'd0           MIIM PHY address (FIAD)
// MII_CLKDIV  8'd10          MIIMODER[7:0]
// TX_BD_NUM   8'h40          TX_BD_NUM register value
// INT_MASK    32'h0000_007F  INT_MASK register value
// MODER_VAL   32'h0000_A403  final MODER: RXEN|TXEN|FULLD|CRCEN|PAD
// POLL_GAP    16'd1000       idle cycles between link polls (>=1)
// MAX_POLL    8'd16          link polls before error (>=1)
// ACK_TIMEOUT 8'd255         max cycles waiting for m_ready per access
// PORTS
// clk       in   1       system clock
// rst       in   1       synchronous, active-high reset
// start     in   1       1-cycle pulse; begins sequence from IDLE/DONE/ERR
// busy      out  1       sequence in progress (owns ethmac slave port)
// done      out  1       sticky; sequence completed, link up
// err       out  1       sticky; ack timeout or poll exhaustion
// link_up   out  1       last BMSR read had bit 2 set
// m_valid   out  1       IOb request to ethmac slave
// m_address out  ADDR_W  byte address of register
// m_wdata   out  DATA_W  write data
// m_wstrb   out  DATA_W/8  4'hF write, 4'h0 read
// m_rdata   in   DATA_W  read data, valid with m_ready
// m_ready   in   1       1-cycle access completion
// BEHAVIOUR
// - Reset: all outputs 0; FSM -> IDLE; poll/timeout counters 0. Reset mid-sequence aborts at the next edge, no completion wait.
// - Reset mid-sequence: m_valid is 0 from that edge onward.
// - IOb rule: m_valid/m_address/m_wdata/m_wstrb are set at an edge and held stable until the cycle m_ready=1.
// - IOb rule: m_valid drops at the following edge. At most one access outstanding.
// - IOb rule: m_rdata is captured only when m_ready=1. m_ready seen while m_valid=0 is ignored.
// - Timeout: ACK_TIMEOUT cycles with m_valid=1 and no m_ready -> drop m_valid, go ERR.
// - start: accepted only when busy=0. Clears done/err/link_up, sets busy, poll count=0. Ignored while busy.
// - States and accesses (W=write 4'hF, R=read 4'h0):
//   CFG    W 0x28=MII_CLKDIV; W 0x40=MAC[31:0]; W 0x44=MAC[47:32]; W 0x20=TX_BD_NUM; W 0x08=INT_MASK (table index 0..4, in order).
//   MADDR  W 0x30={19'b0,5'd1,3'b0,PHY_ADDR}  (RGAD=1 BMSR, FIAD=PHY_ADDR)
//   MCMD   W 0x2C=32'h2 (RSTAT)
//   MSTAT  R 0x3C; bit1 BUSY=1 -> repeat MSTAT; else -> MRX
//   MRX    R 0x38; link_up<=rdata[2]; rdata[2]=1 -> EN.
//          rdata[2]=0: poll count+1; count==MAX_POLL -> ERR, else -> GAP.
//   GAP    wait POLL_GAP cycles, no access -> MADDR
//   EN     W 0x00=MODER_VAL -> DONE
//   DONE   busy=0, done=1;   ERR: busy=0, err=1; both wait for start
// - MSTAT re-polls are not counted against MAX_POLL; they are bounded only by per-access ACK_TIMEOUT.
// - Minimum latency (link up on first poll, 1-cycle ready): 10 accesses, <=2 cycles each + 1 cycle DONE entry.
// - Counters: poll count 8 bit, gap count 16 bit, timeout count 8 bit; all saturate-free, reloaded on use, no wrap.
// - start and m_ready in same cycle while busy: start ignored, m_ready processed normally.
// STRUCTURE
// - Shared header iob_eth_regs.vh: register byte offsets (MODER 0x00, INT_MASK 0x08, TX_BD_NUM 0x20, ...).
// - iob_eth_regs.vh offsets cont.: MIIMODER 0x28, MIICOMMAND 0x2C, MIIADDRESS 0x30, MIIRX_DATA 0x38, MIISTATUS 0x3C, MAC_ADDR0/1 0x40/0x44.
// - iob_eth_regs.vh bit positions: MIISTATUS_BUSY=1, MIICMD_RSTAT=1, BMSR_LINK=2. FSM state encodings also go in this header.
// - Sub-module iob_eth_access: single-access IOb engine (req/we/addr/wdata in; ack/rdata/timeout out).
//   iob_eth_access owns the hold-until-ready and ACK_TIMEOUT logic. Top FSM only sequences requests.
// TESTING
// 1 reset, start; ethmac model acks in 1 cycle, MIISTATUS BUSY=0, BMSR=0x782D -> exact 10-access
//   order/addr/data as listed; done=1 link_up=1 busy=0.
// 2 BMSR bit2=0 for 3 polls then 1, POLL_GAP=4 -> 4 MADDR/MCMD/MSTAT/MRX rounds, >=4 idle cycles between rounds, done=1.
// 3 BMSR never links, MAX_POLL=2 -> exactly 2 polls, err=1, MODER never written, link_up=0.
// 4 model withholds m_ready on 3rd access, ACK_TIMEOUT=8 -> m_valid high 8 cycles, then 0; err=1 busy=0.
// 5 MIISTATUS BUSY=1 for 5 reads, 3-cycle ready latency -> signals held stable until ready, 6 MSTAT reads, then MRX.
// 6 rst asserted mid-MCMD with m_valid=1 -> next cycle all outputs 0. Second start pulse while busy has no effect.
// 6 (cont.) start after DONE reruns the full sequence.

Source files
------------

// File: rtl/iob_eth_init_seq_pkg.sv
// Shared definitions for the ethmac boot sequencer.
// Holds register byte offsets, bit positions and FSM state encodings.
package iob_eth_init_seq_pkg;

    // ethmac register byte offsets
    localparam int REG_MODER      = 'h00;
    localparam int REG_INT_MASK   = 'h08;
    localparam int REG_TX_BD_NUM  = 'h20;
    localparam int REG_MIIMODER   = 'h28;
    localparam int REG_MIICOMMAND = 'h2C;
    localparam int REG_MIIADDRESS = 'h30;
    localparam int REG_MIIRX_DATA = 'h38;
    localparam int REG_MIISTATUS  = 'h3C;
    localparam int REG_MAC_ADDR0  = 'h40;
    localparam int REG_MAC_ADDR1  = 'h44;

    // Bit positions inside those registers
    localparam int MIISTATUS_BUSY = 1;
    localparam int MIICMD_RSTAT   = 1;
    localparam int BMSR_LINK      = 2;

    // PHY register number of BMSR
    localparam int BMSR_REGAD     = 1;

    // Index of the last entry in the static configuration table
    localparam int CFG_LAST       = 4;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CFG   = 4'd1,
        S_MADDR = 4'd2,
        S_MCMD  = 4'd3,
        S_MSTAT = 4'd4,
        S_MRX   = 4'd5,
        S_GAP   = 4'd6,
        S_EN    = 4'd7,
        S_DONE  = 4'd8,
        S_ERR   = 4'd9
    } state_t;

endpackage

// File: rtl/iob_eth_init_seq_access.sv
// Single-access IOb master engine.
// Launches one request, holds address/data/strobe stable until m_ready,
// and gives up after ACK_TIMEOUT cycles without a response.
module iob_eth_init_seq_access
    import iob_eth_init_seq_pkg::*;
#(
    parameter int         ADDR_W      = 12,
    parameter int         DATA_W      = 32,
    parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
    input  logic                clk,
    input  logic                rst,
    // request side (from the sequencer)
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                active_o,
    output logic                ack_o,
    output logic                timeout_o,
    output logic [DATA_W-1:0]   rdata_o,
    // IOb master side
    output logic                m_valid_o,
    output logic [ADDR_W-1:0]   m_address_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic                m_ready_i
);

    localparam int STRB_W = DATA_W / 8;

    logic                m_valid_q;
    logic [ADDR_W-1:0]   m_address_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [STRB_W-1:0]   m_wstrb_q;
    logic [7:0]          tmo_q;

    // Completion and timeout are reported in the cycle they happen so the
    // sequencer can queue the next request on the same edge m_valid drops.
    assign ack_o       = m_valid_q & m_ready_i;
    assign timeout_o   = m_valid_q & ~m_ready_i & (tmo_q == ACK_TIMEOUT - 8'd1);
    assign rdata_o     = m_rdata_i;
    assign active_o    = m_valid_q;

    assign m_valid_o   = m_valid_q;
    assign m_address_o = m_address_q;
    assign m_wdata_o   = m_wdata_q;
    assign m_wstrb_o   = m_wstrb_q;

    // Launch, hold until ready, drop on ready or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q   <= 1'b0;
            m_address_q <= '0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
            tmo_q       <= 8'd0;
        end else if (!m_valid_q) begin
            if (req_i) begin
                m_valid_q   <= 1'b1;
                m_address_q <= addr_i;
                m_wdata_q   <= wdata_i;
                m_wstrb_q   <= we_i ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
                tmo_q       <= 8'd0;
            end
        end else if (m_ready_i || timeout_o) begin
            m_valid_q <= 1'b0;
        end else begin
            tmo_q <= tmo_q + 8'd1;
        end
    end

endmodule

// File: rtl/iob_eth_init_seq.sv
// Boot-time configuration sequencer for the ethmac core.
// Programs static registers, polls PHY link through MIIM, then enables MODER.
module iob_eth_init_seq
    import iob_eth_init_seq_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int          DATA_W      = 32,
    parameter logic [47:0] MAC_ADDR    = 48'h0200_0000_0001,
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter logic [7:0]  MII_CLKDIV  = 8'd10,
    parameter logic [7:0]  TX_BD_NUM   = 8'h40,
    parameter logic [31:0] INT_MASK    = 32'h0000_007F,
    parameter logic [31:0] MODER_VAL   = 32'h0000_A403,
    parameter logic [15:0] POLL_GAP    = 16'd1000,
    parameter logic [7:0]  MAX_POLL    = 8'd16,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                link_up,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    // Register access issued on entry to a given state (and table index for CFG)
    function automatic acc_t acc_for(input state_t s, input logic [2:0] idx);
        acc_t a;
        a.we    = 1'b1;
        a.addr  = '0;
        a.wdata = '0;
        case (s)
            S_CFG: begin
                case (idx)
                    3'd0: begin a.addr = ADDR_W'(REG_MIIMODER);  a.wdata = DATA_W'(MII_CLKDIV);       end
                    3'd1: begin a.addr = ADDR_W'(REG_MAC_ADDR0); a.wdata = DATA_W'(MAC_ADDR[31:0]);   end
                    3'd2: begin a.addr = ADDR_W'(REG_MAC_ADDR1); a.wdata = DATA_W'(MAC_ADDR[47:32]);  end
                    3'd3: begin a.addr = ADDR_W'(REG_TX_BD_NUM); a.wdata = DATA_W'(TX_BD_NUM);        end
                    default: begin a.addr = ADDR_W'(REG_INT_MASK); a.wdata = DATA_W'(INT_MASK);       end
                endcase
            end
            S_MADDR: begin
                a.addr  = ADDR_W'(REG_MIIADDRESS);
                a.wdata = DATA_W'({5'(BMSR_REGAD), 3'b000, PHY_ADDR});
            end
            S_MCMD: begin
                a.addr  = ADDR_W'(REG_MIICOMMAND);
                a.wdata = DATA_W'(32'd1 << MIICMD_RSTAT);
            end
            S_MSTAT: begin
                a.we   = 1'b0;
                a.addr = ADDR_W'(REG_MIISTATUS);
            end
            S_MRX: begin
                a.we   = 1'b0;
                a.addr = ADDR_W'(REG_MIIRX_DATA);
            end
            S_EN: begin
                a.addr  = ADDR_W'(REG_MODER);
                a.wdata = DATA_W'(MODER_VAL);
            end
            default: a.we = 1'b0;
        endcase
        return a;
    endfunction

    state_t       state_q;
    logic [2:0]   cfg_idx_q;
    logic [7:0]   poll_q;
    logic [15:0]  gap_q;
    logic         busy_q;
    logic         done_q;
    logic         err_q;
    logic         link_up_q;
    logic         req_valid_q;
    acc_t         req_q;

    logic              acc_active;
    logic              acc_ack;
    logic              acc_timeout;
    logic [DATA_W-1:0] acc_rdata;

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign link_up = link_up_q;

    iob_eth_init_seq_access #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_access (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_valid_q),
        .we_i        (req_q.we),
        .addr_i      (req_q.addr),
        .wdata_i     (req_q.wdata),
        .active_o    (acc_active),
        .ack_o       (acc_ack),
        .timeout_o   (acc_timeout),
        .rdata_o     (acc_rdata),
        .m_valid_o   (m_valid),
        .m_address_o (m_address),
        .m_wdata_o   (m_wdata),
        .m_wstrb_o   (m_wstrb),
        .m_rdata_i   (m_rdata),
        .m_ready_i   (m_ready)
    );

    // Sequencer: queue one request per state, advance on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cfg_idx_q   <= 3'd0;
            poll_q      <= 8'd0;
            gap_q       <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            link_up_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_q       <= '0;
        end else if (!busy_q) begin
            if (start) begin
                state_q     <= S_CFG;
                cfg_idx_q   <= 3'd0;
                poll_q      <= 8'd0;
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
                err_q       <= 1'b0;
                link_up_q   <= 1'b0;
                req_valid_q <= 1'b1;
                req_q       <= acc_for(S_CFG, 3'd0);
            end
        end else begin
            // The engine takes the request on the edge it sees it while idle
            if (req_valid_q && !acc_active) begin
                req_valid_q <= 1'b0;
            end

            if (acc_timeout) begin
                state_q     <= S_ERR;
                busy_q      <= 1'b0;
                err_q       <= 1'b1;
                req_valid_q <= 1'b0;
            end else if (acc_ack) begin
                case (state_q)
                    S_CFG: begin
                        if (cfg_idx_q == 3'(CFG_LAST)) begin
                            state_q     <= S_MADDR;
                            req_valid_q <= 1'b1;
                            req_q       <= acc_for(S_MADDR, 3'd0);
                        end else begin
                            cfg_idx_q   <= cfg_idx_q + 3'd1;
                            req_valid_q <= 1'b1;
                            req_q       <= acc_for(S_CFG, cfg_idx_q + 3'd1);
                        end
                    end
                    S_MADDR: begin
                        state_q     <= S_MCMD;
                        req_valid_q <= 1'b1;
                        req_q       <= acc_for(S_MCMD, 3'd0);
                    end
                    S_MCMD: begin
                        state_q     <= S_MSTAT;
                        req_valid_q <= 1'b1;
                        req_q       <= acc_for(S_MSTAT, 3'd0);
                    end
                    S_MSTAT: begin
                        // MIIM still busy: read status again, not counted as a poll
                        if (acc_rdata[MIISTATUS_BUSY]) begin
                            req_valid_q <= 1'b1;
                            req_q       <= acc_for(S_MSTAT, 3'd0);
                        end else begin
                            state_q     <= S_MRX;
                            req_valid_q <= 1'b1;
                            req_q       <= acc_for(S_MRX, 3'd0);
                        end
                    end
                    S_MRX: begin
                        link_up_q <= acc_rdata[BMSR_LINK];
                        if (acc_rdata[BMSR_LINK]) begin
                            state_q     <= S_EN;
                            req_valid_q <= 1'b1;
                            req_q       <= acc_for(S_EN, 3'd0);
                        end else if (poll_q + 8'd1 == MAX_POLL) begin
                            poll_q  <= poll_q + 8'd1;
                            state_q <= S_ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            poll_q  <= poll_q + 8'd1;
                            gap_q   <= 16'd0;
                            state_q <= S_GAP;
                        end
                    end
                    S_EN: begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= state_q;
                endcase
            end else if (state_q == S_GAP) begin
                if (gap_q == POLL_GAP - 16'd1) begin
                    state_q     <= S_MADDR;
                    req_valid_q <= 1'b1;
                    req_q       <= acc_for(S_MADDR, 3'd0);
                end else begin
                    gap_q <= gap_q + 16'd1;
                end
            end
        end
    end

endmodule
